// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline front-end controller: next-PC selects,
// sequencer states and the hardwired zero register.
package pipe_ctrl_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;
    localparam logic [1:0] PC_SEL_RST = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } seq_state_e;

    // True when an ID source operand is read and names the given destination.
    function automatic logic src_match(input logic used, input logic [4:0] src,
                                       input logic [4:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/mdu_wait_counter.sv
// Down-counter for the multi-cycle MDU freeze: loads the remaining wait
// cycles, decrements without wrapping and flags the last wait cycle.
module mdu_wait_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Front-end controller: load-use stalls, MDU freezes and branch/jump redirects
// driving the PC, IF/ID and ID/EX registers. Stall statistics: PC_SEQ_STALL_STATS_EN.
module pc_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic        Uses_Rs,
    input  logic        Uses_Rt,
    input  logic        Ex_MemRead,
    input  logic [4:0]  Ex_Rd,
    input  logic        Ex_Mdu_Start,
    input  logic        Branch_Taken,
    input  logic        Jump,
    output logic        Pc_We,
    output logic [1:0]  Pc_Sel,
    output logic        Ifid_We,
    output logic        Ifid_Flush,
    output logic        Id_Bubble,
    output logic        Ex_Hold,
    output logic [31:0] Lu_Stall_Cnt,
    output logic [31:0] Mdu_Stall_Cnt
);

    // The issue cycle is the first freeze cycle, so the wait state covers the rest.
    localparam logic             MDU_MULTI  = (MDU_LAT > 1);
    localparam logic [CNT_W-1:0] MDU_RELOAD = CNT_W'(MDU_LAT - 1);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       lu;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_last;

    assign lu = Ex_MemRead && (Ex_Rd != REG_ZERO) &&
                (src_match(Uses_Rs, Rs_ID, Ex_Rd) || src_match(Uses_Rt, Rt_ID, Ex_Rd));

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the priority chain can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        Pc_We      = 1'b1;
        Pc_Sel     = PC_SEL_SEQ;
        Ifid_We    = 1'b1;
        Ifid_Flush = 1'b0;
        Id_Bubble  = 1'b0;
        Ex_Hold    = 1'b0;
        if (Clr) begin
            state_d    = RUN;
            Pc_Sel     = PC_SEL_RST;
            Ifid_Flush = 1'b1;
            Id_Bubble  = 1'b1;
        end else if (state_q == MDU_WAIT) begin
            Pc_We   = 1'b0;
            Ifid_We = 1'b0;
            Ex_Hold = 1'b1;
            cnt_dec = 1'b1;
            if (cnt_last) begin
                state_d = RUN;
            end
        end else if (Ex_Mdu_Start) begin
            Pc_We   = 1'b0;
            Ifid_We = 1'b0;
            Ex_Hold = 1'b1;
            if (MDU_MULTI) begin
                state_d  = MDU_WAIT;
                cnt_load = 1'b1;
            end
        end else if (lu) begin
            // A redirect in this cycle is dropped; the branch re-resolves next cycle.
            Pc_We     = 1'b0;
            Ifid_We   = 1'b0;
            Id_Bubble = 1'b1;
        end else if (Jump) begin
            Pc_Sel     = PC_SEL_JMP;
            Ifid_Flush = 1'b1;
        end else if (Branch_Taken) begin
            Pc_Sel     = PC_SEL_BR;
            Ifid_Flush = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    mdu_wait_counter #(
        .CNT_W(CNT_W)
    ) u_mdu_wait_counter (
        .Clk      (Clk),
        .Clr      (Clr),
        .load     (cnt_load),
        .load_val (MDU_RELOAD),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

`ifdef PC_SEQ_STALL_STATS_EN
    logic [31:0] lu_cnt_q;
    logic [31:0] lu_cnt_d;
    logic [31:0] mdu_cnt_q;
    logic [31:0] mdu_cnt_d;
    logic        lu_stall;
    logic        mdu_freeze;

    assign lu_stall   = !Clr && (state_q == RUN) && !Ex_Mdu_Start && lu;
    assign mdu_freeze = !Clr && ((state_q == MDU_WAIT) || Ex_Mdu_Start);

    // Both statistics saturate rather than wrap.
    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        mdu_cnt_d = mdu_cnt_q;
        if (lu_stall && (lu_cnt_q != '1)) begin
            lu_cnt_d = lu_cnt_q + 32'd1;
        end
        if (mdu_freeze && (mdu_cnt_q != '1)) begin
            mdu_cnt_d = mdu_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            lu_cnt_q  <= '0;
            mdu_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign Lu_Stall_Cnt  = lu_cnt_q;
    assign Mdu_Stall_Cnt = mdu_cnt_q;
`else
    assign Lu_Stall_Cnt  = '0;
    assign Mdu_Stall_Cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two instances (MDU_LAT=4 and MDU_LAT=1)
// share stimulus; a freeze-budget reference model predicts every cycle.
module tb_pc_sequencer;

    typedef struct packed {
        logic       clr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [4:0] exrd;
        logic       start;
        logic       br;
        logic       jmp;
    } stim_t;

    typedef struct packed {
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        ifid_we;
        logic        ifid_flush;
        logic        id_bubble;
        logic        ex_hold;
        logic [31:0] lu_cnt;
        logic [31:0] mdu_cnt;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic [4:0]  Rs_ID = '0;
    logic [4:0]  Rt_ID = '0;
    logic        Uses_Rs = 1'b0;
    logic        Uses_Rt = 1'b0;
    logic        Ex_MemRead = 1'b0;
    logic [4:0]  Ex_Rd = '0;
    logic        Ex_Mdu_Start = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic        Jump = 1'b0;

    logic        a_pc_we, a_ifid_we, a_ifid_flush, a_id_bubble, a_ex_hold;
    logic [1:0]  a_pc_sel;
    logic [31:0] a_lu_cnt, a_mdu_cnt;
    logic        b_pc_we, b_ifid_we, b_ifid_flush, b_id_bubble, b_ex_hold;
    logic [1:0]  b_pc_sel;
    logic [31:0] b_lu_cnt, b_mdu_cnt;

    int total = 0;
    int bad   = 0;
    pair_t exp_q[$];

    int          f4 = 0, f1 = 0;
    int unsigned lu4 = 0, mdu4 = 0, lu1 = 0, mdu1 = 0;

    always #5 Clk = ~Clk;

    pc_sequencer #(.MDU_LAT(4), .CNT_W(4)) dut_lat4 (
        .Clk(Clk), .Clr(Clr), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Uses_Rs(Uses_Rs), .Uses_Rt(Uses_Rt), .Ex_MemRead(Ex_MemRead),
        .Ex_Rd(Ex_Rd), .Ex_Mdu_Start(Ex_Mdu_Start),
        .Branch_Taken(Branch_Taken), .Jump(Jump),
        .Pc_We(a_pc_we), .Pc_Sel(a_pc_sel), .Ifid_We(a_ifid_we),
        .Ifid_Flush(a_ifid_flush), .Id_Bubble(a_id_bubble), .Ex_Hold(a_ex_hold),
        .Lu_Stall_Cnt(a_lu_cnt), .Mdu_Stall_Cnt(a_mdu_cnt)
    );

    pc_sequencer #(.MDU_LAT(1), .CNT_W(4)) dut_lat1 (
        .Clk(Clk), .Clr(Clr), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Uses_Rs(Uses_Rs), .Uses_Rt(Uses_Rt), .Ex_MemRead(Ex_MemRead),
        .Ex_Rd(Ex_Rd), .Ex_Mdu_Start(Ex_Mdu_Start),
        .Branch_Taken(Branch_Taken), .Jump(Jump),
        .Pc_We(b_pc_we), .Pc_Sel(b_pc_sel), .Ifid_We(b_ifid_we),
        .Ifid_Flush(b_ifid_flush), .Id_Bubble(b_id_bubble), .Ex_Hold(b_ex_hold),
        .Lu_Stall_Cnt(b_lu_cnt), .Mdu_Stall_Cnt(b_mdu_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: 'fl' is the number of freeze cycles still owed after
    // this one; counts are plain running totals of stall cycles.
    function automatic exp_t model(input stim_t s, input int lat, input int fl,
                                   input int unsigned lun, input int unsigned mdun,
                                   output int nfl, output int unsigned nlu,
                                   output int unsigned nmdu);
        exp_t e;
        logic hazard;
        hazard = s.mr && (s.exrd != 5'd0) &&
                 ((s.urs && s.rs == s.exrd) || (s.urt && s.rt == s.exrd));
        e = '{pc_we: 1'b1, pc_sel: 2'd0, ifid_we: 1'b1, ifid_flush: 1'b0,
              id_bubble: 1'b0, ex_hold: 1'b0, lu_cnt: 32'd0, mdu_cnt: 32'd0};
`ifdef PC_SEQ_STALL_STATS_EN
        e.lu_cnt  = lun;
        e.mdu_cnt = mdun;
`endif
        nfl = fl; nlu = lun; nmdu = mdun;
        if (s.clr) begin
            e.pc_sel = 2'd3; e.ifid_flush = 1'b1; e.id_bubble = 1'b1;
            nfl = 0; nlu = 0; nmdu = 0;
        end else if (fl > 0 || s.start) begin
            e.pc_we = 1'b0; e.ifid_we = 1'b0; e.ex_hold = 1'b1;
            nfl  = (fl > 0) ? fl - 1 : lat - 1;
            nmdu = mdun + 1;
        end else if (hazard) begin
            e.pc_we = 1'b0; e.ifid_we = 1'b0; e.id_bubble = 1'b1;
            nlu = lun + 1;
        end else if (s.jmp || s.br) begin
            e.pc_sel = s.jmp ? 2'd2 : 2'd1;
            e.ifid_flush = 1'b1;
        end
        return e;
    endfunction

    task automatic step(input stim_t s);
        pair_t p;
        int nf4, nf1;
        int unsigned nlu4, nmdu4, nlu1, nmdu1;
        Clr = s.clr; Rs_ID = s.rs; Rt_ID = s.rt; Uses_Rs = s.urs; Uses_Rt = s.urt;
        Ex_MemRead = s.mr; Ex_Rd = s.exrd; Ex_Mdu_Start = s.start;
        Branch_Taken = s.br; Jump = s.jmp;
        p.a = model(s, 4, f4, lu4, mdu4, nf4, nlu4, nmdu4);
        p.b = model(s, 1, f1, lu1, mdu1, nf1, nlu1, nmdu1);
        exp_q.push_back(p);
        @(posedge Clk);
        f4 = nf4; lu4 = nlu4; mdu4 = nmdu4;
        f1 = nf1; lu1 = nlu1; mdu1 = nmdu1;
        #1;
    endtask

    function automatic stim_t idle();
        return '0;
    endfunction

    // Monitor: outputs are sampled mid-cycle on the falling edge.
    initial begin
        pair_t p;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                check("lat4.pc_we",      32'(a_pc_we),      32'(p.a.pc_we));
                check("lat4.pc_sel",     32'(a_pc_sel),     32'(p.a.pc_sel));
                check("lat4.ifid_we",    32'(a_ifid_we),    32'(p.a.ifid_we));
                check("lat4.ifid_flush", 32'(a_ifid_flush), 32'(p.a.ifid_flush));
                check("lat4.id_bubble",  32'(a_id_bubble),  32'(p.a.id_bubble));
                check("lat4.ex_hold",    32'(a_ex_hold),    32'(p.a.ex_hold));
                check("lat4.lu_cnt",     a_lu_cnt,          p.a.lu_cnt);
                check("lat4.mdu_cnt",    a_mdu_cnt,         p.a.mdu_cnt);
                check("lat1.pc_we",      32'(b_pc_we),      32'(p.b.pc_we));
                check("lat1.pc_sel",     32'(b_pc_sel),     32'(p.b.pc_sel));
                check("lat1.ifid_we",    32'(b_ifid_we),    32'(p.b.ifid_we));
                check("lat1.ifid_flush", 32'(b_ifid_flush), 32'(p.b.ifid_flush));
                check("lat1.id_bubble",  32'(b_id_bubble),  32'(p.b.id_bubble));
                check("lat1.ex_hold",    32'(b_ex_hold),    32'(p.b.ex_hold));
                check("lat1.lu_cnt",     b_lu_cnt,          p.b.lu_cnt);
                check("lat1.mdu_cnt",    b_mdu_cnt,         p.b.mdu_cnt);
            end
        end
    end

    initial begin
        stim_t s;
        // Unchecked power-up reset so every register holds a known value.
        @(posedge Clk);
        #1;

        // Reset held two cycles, then release.
        s = idle(); s.clr = 1'b1;
        step(s); step(s);
        step(idle());

        // Load-use on rs, then the same pattern against the zero register.
        s = idle(); s.mr = 1'b1; s.exrd = 5'd8; s.rs = 5'd8; s.urs = 1'b1;
        step(s);
        step(idle());
        s.exrd = 5'd0; s.rs = 5'd0;
        step(s);
        s = idle(); s.mr = 1'b1; s.exrd = 5'd17; s.rt = 5'd17; s.urt = 1'b1;
        step(s);

        // Load-use beats a taken branch; the branch lands the following cycle.
        s = idle(); s.mr = 1'b1; s.exrd = 5'd5; s.rs = 5'd5; s.urs = 1'b1; s.br = 1'b1;
        step(s);
        s = idle(); s.br = 1'b1;
        step(s);
        s.jmp = 1'b1;
        step(s);

        // MDU freeze with Jump held throughout, then the jump on the 5th cycle.
        s = idle(); s.start = 1'b1; s.jmp = 1'b1;
        step(s);
        s.start = 1'b0;
        for (int i = 0; i < 4; i++) step(s);
        step(idle());

        // Reset on the second freeze cycle.
        s = idle(); s.start = 1'b1;
        step(s);
        s = idle(); s.clr = 1'b1;
        step(s);
        step(idle());
        step(idle());

        // Statistics: three load-use stalls and one MDU op, then clear.
        s = idle(); s.clr = 1'b1;
        step(s);
        s = idle(); s.mr = 1'b1; s.exrd = 5'd3; s.rt = 5'd3; s.urt = 1'b1;
        for (int i = 0; i < 3; i++) step(s);
        s = idle(); s.start = 1'b1;
        step(s);
        for (int i = 0; i < 4; i++) step(idle());
        s = idle(); s.clr = 1'b1;
        step(s);
        step(idle());

        // Randomized traffic over a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            s.clr   = ($urandom_range(0, 39) == 0);
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom_range(0, 1));
            s.urt   = 1'($urandom_range(0, 1));
            s.mr    = 1'($urandom_range(0, 1));
            s.exrd  = 5'($urandom_range(0, 3));
            s.start = ($urandom_range(0, 7) == 0);
            s.br    = 1'($urandom_range(0, 1));
            s.jmp   = ($urandom_range(0, 3) == 0);
            step(s);
        end
        step(idle());

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge Clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Pipeline front-end controller that drives the PC register's write enable and next-PC select, plus IF/ID and ID/EX control.
- Detects load-use hazards and freezes the front end.
- Sequences multi-cycle MDU (multiply/divide) freezes.
- Applies branch/jump redirects with IF/ID flush.
- Sits between ID/EX decode signals and the PC register, the IF/ID register and the ID/EX register.

Parameters:
- MDU_LAT, 4, total freeze cycles per MDU op including the issue cycle; legal range 1..15.
- CNT_W, 4, width of the MDU wait counter.

Ports:
- Clk  in  1  clock, rising edge
- Clr  in  1  synchronous reset, active-high
- Rs_ID  in  5  ID-stage rs field
- Rt_ID  in  5  ID-stage rt field
- Uses_Rs  in  1  ID instruction reads rs
- Uses_Rt  in  1  ID instruction reads rt
- Ex_MemRead  in  1  EX instruction is a load
- Ex_Rd  in  5  EX destination register
- Ex_Mdu_Start  in  1  EX instruction is an MDU op, valid for one cycle
- Branch_Taken  in  1  ID branch resolved taken
- Jump  in  1  ID jump/jal/jr
- Pc_We  out  1  PC register write enable; 0 = stall
- Pc_Sel  out  2  next-PC mux select: 00 PC+4, 01 branch target, 10 jump target, 11 reset vector
- Ifid_We  out  1  IF/ID write enable
- Ifid_Flush  out  1  IF/ID loads a NOP
- Id_Bubble  out  1  ID/EX loads a NOP
- Ex_Hold  out  1  ID/EX and EX/MEM hold
- Lu_Stall_Cnt  out  32  load-use stall cycle counter (optional feature)
- Mdu_Stall_Cnt  out  32  MDU freeze cycle counter (optional feature)

Behaviour:
- Clock and reset: one clock, Clk. Reset Clr is synchronous and active-high.
- While Clr=1:
  - state ← RUN, counter ← 0.
  - Outputs: Pc_We=1, Pc_Sel=11, Ifid_Flush=1, Id_Bubble=1, Ifid_We=1, Ex_Hold=0.
- States: RUN, MDU_WAIT. All outputs are combinational from state, counter and inputs.
- Load-use hazard (lu): Ex_MemRead & (Ex_Rd≠0) & ((Uses_Rs & Rs_ID==Ex_Rd) | (Uses_Rt & Rt_ID==Ex_Rd)).
- Redirect (rd): Branch_Taken | Jump. When both are set, Jump wins.
- Output priority in RUN, highest first:
  1. Ex_Mdu_Start: Pc_We=0, Ifid_We=0, Ex_Hold=1, Id_Bubble=0, Ifid_Flush=0, Pc_Sel=00. lu and rd are ignored. If MDU_LAT>1, go to MDU_WAIT with cnt ← MDU_LAT-1. If MDU_LAT=1, stay in RUN.
  2. lu: Pc_We=0, Ifid_We=0, Id_Bubble=1, Ex_Hold=0, Ifid_Flush=0. rd is ignored (the branch is re-evaluated next cycle). Each lu cycle is one stall cycle; there is no state change.
  3. rd: Pc_We=1, Pc_Sel=10 if Jump else 01, Ifid_Flush=1, Ifid_We=1.
  4. Default: Pc_We=1, Pc_Sel=00, Ifid_We=1, all other outputs 0.
- MDU_WAIT:
  - Outputs: Pc_We=0, Ifid_We=0, Ex_Hold=1, Pc_Sel=00. All other outputs 0.
  - Ignores lu, rd and Ex_Mdu_Start.
  - cnt decrements each cycle. When cnt==1, the next state is RUN.
  - Total freeze = exactly MDU_LAT cycles.
- Ex_Mdu_Start is only sampled in RUN. An upstream re-assertion during the freeze is a protocol violation and is ignored.
- Clr mid-freeze aborts to RUN on the next edge; the counter clears.
- Counter arithmetic is unsigned CNT_W bits and never wraps.

Optional Feature:
- Macro: PC_SEQ_STALL_STATS_EN.
- Defined:
  - Lu_Stall_Cnt increments on every cycle in which lu causes a stall (priority 2).
  - Mdu_Stall_Cnt increments on every freeze cycle (priority 1 and MDU_WAIT).
  - Both counters are 32-bit, saturate at 0xFFFFFFFF and clear on Clr.
- Undefined: both ports are present and tied to 0; no counter registers are built.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_JMP=2'b10, PC_SEL_RST=2'b11.
  - State encoding RUN=1'b0, MDU_WAIT=1'b1.
  - REG_ZERO=5'd0.
- Sub-module mdu_wait_counter: load, decrement and last flag, CNT_W wide.
- Hazard compare and output priority stay in pc_sequencer.

Test Plan:
- Reset: Clr=1 for 2 cycles → Pc_Sel=11, Pc_We=1, Ifid_Flush=1, Id_Bubble=1. Release → Pc_Sel=00, Pc_We=1, all others 0.
- Load-use: Ex_MemRead=1, Ex_Rd=8, Rs_ID=8, Uses_Rs=1 for 1 cycle → Pc_We=0, Ifid_We=0, Id_Bubble=1 that cycle only. Same stimulus with Ex_Rd=0 → no stall.
- Load-use vs branch: lu and Branch_Taken=1 in the same cycle → stall, Pc_Sel=00, Ifid_Flush=0. Next cycle (lu=0, Branch_Taken=1) → Pc_Sel=01, Ifid_Flush=1.
- MDU freeze: MDU_LAT=4, Ex_Mdu_Start pulse → Pc_We=0 and Ex_Hold=1 for exactly 4 cycles, Jump=1 held throughout ignored. 5th cycle → Pc_Sel=10, Ifid_Flush=1.
- Reset mid-freeze: Clr=1 on the 2nd freeze cycle → next cycle state RUN, Pc_We=1. MDU_LAT=1 → single-cycle freeze, no MDU_WAIT entry.
- Stats (PC_SEQ_STALL_STATS_EN): 3 lu stalls + one MDU_LAT=4 op → Lu_Stall_Cnt=3, Mdu_Stall_Cnt=4. Clr → both 0.
